// File: rtl/i2s_pkg.sv
// Shared I2S transmitter types and constants.
// DATA_W/SLOT_W/FRAME_BITS fix the 24-bit-in-32-bit-slot stereo framing,
// state_e is the transmitter FSM encoding, frame_t is one {left, right} FIFO word.
package i2s_pkg;

    localparam int unsigned DATA_W     = 24;
    localparam int unsigned SLOT_W     = 32;
    localparam int unsigned FRAME_BITS = 64;
    localparam int unsigned POS_W      = $clog2(SLOT_W);
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } frame_t;

    // Serial bit for slot position pos: one-bit delay, MSB first, zero padding after the LSB.
    function automatic logic slot_bit(input logic [DATA_W-1:0] sample,
                                      input logic [POS_W-1:0]  pos);
        logic [POS_W-1:0] idx;
        idx = POS_W'(DATA_W) - pos;
        if ((pos != '0) && (pos <= POS_W'(DATA_W))) begin
            return sample[idx];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO of stereo frames.
// Ports: clk/rst (sync, active-high), push + wr_data, pop -> rd_data (head word,
// valid while !empty), full/empty flags, ready (registered "can accept", 0 in reset).
// The caller only pushes when !full and only pops when !empty.
module sample_fifo
    import i2s_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  frame_t wr_data,
    input  logic   pop,
    output frame_t rd_data,
    output logic   full,
    output logic   empty,
    output logic   ready
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    frame_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    // Occupancy after this edge; flags are registered from it so they are valid immediately.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers, count and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            ready    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
            full  <= (cnt_d == CW'(FIFO_DEPTH));
            empty <= (cnt_d == '0);
            ready <= (cnt_d != CW'(FIFO_DEPTH));
        end
    end

    // Storage, no reset needed: contents are only read while non-empty.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q];

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers stereo frames in a FIFO and serialises them as
// 24-bit samples in 32-bit slots (one-bit delay, MSB first).
// Ports: clk, rst (sync, active-high), en (level enable), s_valid/s_ready/s_left/s_right
// (frame input handshake), bclk/lrclk/sdata (I2S bus), underrun (1-clk pulse when a
// frame starts with nothing buffered). All outputs are registered.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV   = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              underrun
);

    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d, nxt_bit;
    logic               bclk_q, bclk_d;
    logic               lrclk_q, lrclk_d;
    logic               sdata_q, sdata_d;
    logic               underrun_q, underrun_d;
    frame_t             shadow_q, shadow_d;
    logic               load;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    frame_t             fifo_rd_data;
    frame_t             fifo_wr_data;

    assign fifo_wr_data = '{left: s_left, right: s_right};
    assign fifo_push    = s_valid && s_ready && !fifo_full;

    sample_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (fifo_wr_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .ready   (s_ready)
    );

    // State and datapath register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
            shadow_q   <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            bclk_q     <= bclk_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
            shadow_q   <= shadow_d;
        end
    end

    // Next-state, bit timing and frame loading.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;
        shadow_d   = shadow_q;
        load       = 1'b0;
        nxt_bit    = bit_q + BIT_W'(1);

        case (state_q)
            IDLE: begin
                div_d   = '0;
                bit_d   = '0;
                bclk_d  = 1'b0;
                lrclk_d = 1'b0;
                sdata_d = 1'b0;
                if (en) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (div_q == DIV_W'(BCLK_DIV - 1)) begin
                    div_d  = '0;
                    bclk_d = ~bclk_q;
                    // Falling toggle: advance to the next bit; new slot bit 0 is always 0,
                    // so the old shadow is fine even on the wrap edge that reloads it.
                    if (bclk_q) begin
                        bit_d   = nxt_bit;
                        lrclk_d = nxt_bit[BIT_W-1];
                        sdata_d = slot_bit(nxt_bit[BIT_W-1] ? shadow_q.right : shadow_q.left,
                                           nxt_bit[POS_W-1:0]);
                        if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                            if (en) load    = 1'b1;
                            else    state_d = IDLE;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame load: pop if something is buffered, otherwise send silence and flag it.
        fifo_pop = load && !fifo_empty;
        if (load) begin
            shadow_d   = fifo_empty ? '0 : fifo_rd_data;
            underrun_d = fifo_empty;
        end
    end

    assign bclk     = bclk_q;
    assign lrclk    = lrclk_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx (BCLK_DIV = 2, FIFO_DEPTH = 4).
// A frame-level reference model (queue of buffered frames, clock count since frame
// start) predicts every output each clk; directed scenarios add fixed-pattern checks.
module tb_i2s_tx;

    localparam int unsigned DIV       = 2;
    localparam int unsigned DEPTH     = 4;
    localparam int          FRAME_CLK = 64 * 2 * DIV;

    logic        clk;
    logic        rst;
    logic        en;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;

    i2s_tx #(
        .BCLK_DIV   (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_left   (s_left),
        .s_right  (s_right),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [47:0] q[$];
    logic [47:0] cur = '0;
    logic        m_running = 1'b0;
    int          m_t = 0;
    logic        m_ready = 1'b0;
    logic        m_under = 1'b0;
    logic        last_push = 1'b0;

    // Observation helpers
    logic        prev_bclk = 1'b0;
    logic [63:0] cap_sd = '0;
    logic [63:0] cap_lr = '0;
    int          under_seen = 0;
    int          dut_acc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clk: model the edge with the inputs present at it, then compare all outputs.
    task automatic step();
        logic        start;
        logic        e_bclk, e_lr, e_sd;
        logic [23:0] samp;
        int          b, p;
        if (s_valid && s_ready) dut_acc++;
        @(posedge clk);
        @(negedge clk);
        last_push = 1'b0;
        m_under   = 1'b0;
        if (rst) begin
            m_running = 1'b0;
            m_t       = 0;
            q.delete();
            cur       = '0;
            m_ready   = 1'b0;
        end else begin
            last_push = s_valid && m_ready;
            start     = 1'b0;
            if (!m_running) begin
                if (en) begin
                    m_running = 1'b1;
                    m_t       = 0;
                    start     = 1'b1;
                end
            end else begin
                m_t++;
                if (m_t == FRAME_CLK) begin
                    m_t = 0;
                    if (en) start = 1'b1;
                    else    m_running = 1'b0;
                end
            end
            if (start) begin
                if (q.size() > 0) cur = q.pop_front();
                else begin
                    cur     = '0;
                    m_under = 1'b1;
                end
            end
            if (last_push) q.push_back({s_left, s_right});
            m_ready = (q.size() < DEPTH);
        end

        e_bclk = 1'b0;
        e_lr   = 1'b0;
        e_sd   = 1'b0;
        if (m_running) begin
            b      = m_t / (2 * DIV);
            p      = b % 32;
            e_bclk = ((m_t / DIV) % 2) == 1;
            e_lr   = (b >= 32);
            samp   = (b < 32) ? cur[47:24] : cur[23:0];
            if (p >= 1 && p <= 24) e_sd = samp[24 - p];
        end

        chk("bclk",     64'(bclk),     64'(e_bclk));
        chk("lrclk",    64'(lrclk),    64'(e_lr));
        chk("sdata",    64'(sdata),    64'(e_sd));
        chk("underrun", 64'(underrun), 64'(m_under));
        chk("s_ready",  64'(s_ready),  64'(m_ready));

        if (underrun) under_seen++;
        if (!prev_bclk && bclk) begin
            cap_sd = {cap_sd[62:0], sdata};
            cap_lr = {cap_lr[62:0], lrclk};
        end
        prev_bclk = bclk;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_frame(input logic [23:0] l, input logic [23:0] r);
        logic done;
        done    = 1'b0;
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        for (int i = 0; i < 600 && !done; i++) begin
            step();
            done = last_push;
        end
        s_valid = 1'b0;
        if (!done) chk("push_timeout", 64'(done), 64'(1));
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        s_valid = 1'b0;
        s_left  = '0;
        s_right = '0;
        run(3);
        rst = 1'b0;
        run(2);

        // Known data frame, then stop at its end.
        push_frame(24'hA5A5A5, 24'h800000);
        en     = 1'b1;
        cap_sd = '0;
        cap_lr = '0;
        step();
        en = 1'b0;
        run(FRAME_CLK);
        chk("frame_left",  64'(cap_sd[63:32]), 64'(32'h52D2D280));
        chk("frame_right", 64'(cap_sd[31:0]),  64'(32'h40000000));
        chk("frame_lr",    cap_lr,             64'h00000000_FFFFFFFF);
        run(10);

        // Underrun frame, then a frame pushed mid-frame follows it.
        under_seen = 0;
        en = 1'b1;
        step();
        run(99);
        push_frame(24'h000001, 24'($urandom));
        run(FRAME_CLK - 101);
        cap_sd = '0;
        step();
        en = 1'b0;
        run(FRAME_CLK);
        chk("under_count", 64'(under_seen), 64'(1));
        chk("lsb_left",    64'(cap_sd[63:32]), 64'(32'h00000080));

        // Backpressure: five offered while idle, four accepted.
        dut_acc = 0;
        s_valid = 1'b1;
        s_left  = 24'($urandom);
        s_right = 24'($urandom);
        for (int i = 0; i < 10; i++) begin
            step();
            if (last_push) begin
                s_left  = 24'($urandom);
                s_right = 24'($urandom);
            end
        end
        chk("bp_accepted", 64'(dut_acc), 64'(4));
        chk("bp_full",     64'(s_ready), 64'(0));
        en = 1'b1;
        step();
        chk("bp_ready", 64'(s_ready), 64'(1));
        step();
        s_valid = 1'b0;
        run(4 * FRAME_CLK + 100);
        en = 1'b0;
        run(FRAME_CLK);

        // Stop requested at bit 10; remaining frame goes out after re-enable.
        push_frame(24'($urandom), 24'($urandom));
        push_frame(24'($urandom), 24'($urandom));
        en = 1'b1;
        step();
        run(40);
        en = 1'b0;
        run(FRAME_CLK - 40);
        run(20);
        chk("stop_idle_bclk", 64'(bclk), 64'(0));
        en = 1'b1;
        step();
        en = 1'b0;
        run(FRAME_CLK);

        // Reset at bit 40 with traffic; FIFO must come back empty.
        push_frame(24'($urandom), 24'($urandom));
        push_frame(24'($urandom), 24'($urandom));
        en = 1'b1;
        step();
        run(160);
        s_valid = 1'b1;
        s_left  = 24'($urandom);
        s_right = 24'($urandom);
        rst     = 1'b1;
        run(3);
        chk("rst_ready", 64'(s_ready), 64'(0));
        rst     = 1'b0;
        s_valid = 1'b0;
        en      = 1'b0;
        step();
        chk("rst_release_ready", 64'(s_ready), 64'(1));
        en = 1'b1;
        step();
        chk("rst_under", 64'(underrun), 64'(1));
        en = 1'b0;
        run(FRAME_CLK);

        // Randomised traffic with enable toggling.
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(2) == 0);
            s_left  = 24'($urandom);
            s_right = 24'($urandom);
            if ($urandom_range(199) == 0) en = ~en;
            step();
        end
        s_valid = 1'b0;
        en      = 1'b0;
        run(FRAME_CLK + 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
